// File: rtl/uno_pkg.sv
// Types shared by the uno sequencer, offset generator and PE datapath.
package uno_pkg;

  localparam int unsigned MAX_TERMS_DEF = 16;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } uno_mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OFFSET = 3'd1,
    S_ITER   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESP   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/uno_term_cnt.sv
// Loadable down-counter with a companion up-index; reused for iteration and drain phases.
module uno_term_cnt #(
  parameter int unsigned CNT_BW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CNT_BW-1:0] load_val_i,
  input  logic              step_i,
  output logic [CNT_BW-1:0] idx_o,
  output logic              last_o
);

  logic [CNT_BW-1:0] rem_q;
  logic [CNT_BW-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      rem_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      rem_q <= load_val_i;
      idx_q <= '0;
    end else if (step_i && (rem_q != '0)) begin
      rem_q <= rem_q - CNT_BW'(1);
      idx_q <= idx_q + CNT_BW'(1);
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (rem_q == CNT_BW'(1));

endmodule

// File: rtl/uno_seq_ctrl.sv
// Per-PE sequencer for one gemm/uno op: accept, offset init, iterate terms,
// drain the MAC pipeline, then return the captured accumulator.
module uno_seq_ctrl
  import uno_pkg::*;
#(
  parameter int unsigned MUL_BW    = 16,
  parameter int unsigned ACC_BW    = 32,
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
  parameter int unsigned TERM_BW   = 5,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_mode_i,
  input  logic [MUL_BW-1:0]  req_x_i,
  input  logic [TERM_BW-1:0] req_terms_i,
  input  logic               flush_i,
  output logic [1:0]         gemm_uno_o,
  output logic [MUL_BW-1:0]  x_o,
  output logic               acc_init_o,
  output logic               acc_en_o,
  output logic [TERM_BW-1:0] term_idx_o,
  input  logic [ACC_BW-1:0]  acc_i,
  output logic               busy_o,
  output logic               resp_valid_o,
  output logic [ACC_BW-1:0]  resp_data_o,
  input  logic               resp_ready_i
);

  seq_state_e         state_q, state_d;
  uno_mode_e          mode_q;
  logic [MUL_BW-1:0]  x_q;
  logic [TERM_BW-1:0] terms_q;
  logic [TERM_BW-1:0] terms_eff;
  logic [TERM_BW-1:0] term_idx_q, term_idx_d;
  logic               req_ready_q, acc_init_q, acc_en_q, busy_q, resp_valid_q;
  logic [ACC_BW-1:0]  resp_data_q;

  logic               accept, capture;
  logic               cnt_clr, cnt_load, cnt_step, cnt_last;
  logic [TERM_BW-1:0] cnt_load_val, cnt_idx;

  assign terms_eff = (32'(req_terms_i) > MAX_TERMS) ? TERM_BW'(MAX_TERMS) : req_terms_i;

  // Next state; flush from any busy state overrides every other transition.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          accept  = 1'b1;
          state_d = S_OFFSET;
        end
      end
      S_OFFSET: state_d = (terms_q != '0) ? S_ITER : S_DRAIN;
      S_ITER:   if (cnt_last) state_d = S_DRAIN;
      S_DRAIN: begin
        if (cnt_last) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:   if (resp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      capture = 1'b0;
    end
  end

  always_comb begin
    cnt_clr      = flush_i && (state_q != S_IDLE);
    cnt_load     = ((state_d == S_ITER)  && (state_q != S_ITER)) ||
                   ((state_d == S_DRAIN) && (state_q != S_DRAIN));
    cnt_load_val = (state_d == S_ITER) ? terms_q : TERM_BW'(PIPE_LAT);
    cnt_step     = (state_q == S_ITER) || (state_q == S_DRAIN);
    term_idx_d   = '0;
    if (state_d == S_ITER) begin
      term_idx_d = (state_q == S_ITER) ? (cnt_idx + TERM_BW'(1)) : '0;
    end
  end

  uno_term_cnt #(
    .CNT_BW (TERM_BW)
  ) u_term_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .step_i     (cnt_step),
    .idx_o      (cnt_idx),
    .last_o     (cnt_last)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= GEMM;
      x_q          <= '0;
      terms_q      <= '0;
      term_idx_q   <= '0;
      req_ready_q  <= 1'b0;
      acc_init_q   <= 1'b0;
      acc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      term_idx_q   <= term_idx_d;
      req_ready_q  <= (state_d == S_IDLE);
      acc_init_q   <= (state_d == S_OFFSET);
      acc_en_q     <= (state_d == S_ITER);
      busy_q       <= (state_d != S_IDLE);
      resp_valid_q <= (state_d == S_RESP);
      if (accept) begin
        mode_q  <= uno_mode_e'(req_mode_i);
        x_q     <= req_x_i;
        terms_q <= terms_eff;
      end
      if (capture) begin
        resp_data_q <= acc_i;
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign gemm_uno_o   = mode_q;
  assign x_o          = x_q;
  assign acc_init_o   = acc_init_q;
  assign acc_en_o     = acc_en_q;
  assign term_idx_o   = term_idx_q;
  assign busy_o       = busy_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;

endmodule
